// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the fetch PC and issues pipelined instruction
// memory requests under a credit limit. Returned words go into a small in-order
// FIFO that feeds the decoder. Redirects flush the FIFO and drop the responses
// that are still in flight.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  output logic        oIMEM_REQ,
  output logic [31:0] oIMEM_ADDR,
  input  logic        iIMEM_GNT,
  input  logic        iIMEM_RVALID,
  input  logic [31:0] iIMEM_RDATA,
  input  logic        iREDIRECT,
  input  logic [31:0] iREDIRECT_PC,
  output logic        oIR_VALID,
  output logic [31:0] oIR,
  output logic [6:0]  oOpcode,
  output logic [31:0] oPC,
  input  logic        iIR_READY,
  output logic        oMISALIGN
);

  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam int PTRW = $clog2(DEPTH);
  localparam logic [CNTW:0]   LIMIT   = (CNTW+1)'(DEPTH);
  localparam logic [PTRW-1:0] LASTPTR = PTRW'(DEPTH - 1);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

  state_t          r_state;
  logic [31:0]     r_fetchPc;
  logic [31:0]     r_respPc;
  logic [CNTW-1:0] r_inflight;
  logic [CNTW-1:0] r_discard;
  logic [CNTW-1:0] r_count;
  logic [PTRW-1:0] r_rdPtr;
  logic [PTRW-1:0] r_wrPtr;
  logic [31:0]     r_memData [DEPTH];
  logic [31:0]     r_memPc   [DEPTH];
  logic            r_irValid;
  logic [31:0]     r_ir;
  logic [31:0]     r_pc;
  logic            r_misalign;

  logic            w_grant;
  logic            w_pop;
  logic            w_push;
  logic [CNTW:0]   w_used;
  logic [CNTW-1:0] w_inflightNext;
  logic [CNTW-1:0] w_discardDec;
  logic [CNTW-1:0] w_discardNext;
  logic [PTRW-1:0] w_rdPtrInc;
  logic [PTRW-1:0] w_wrPtrInc;
  logic [31:0]     w_redirectPc;

  // Entries held plus requests outstanding must never exceed the FIFO size,
  // so every response always has a slot waiting for it.
  assign w_used     = {1'b0, r_count} + {1'b0, r_inflight};
  assign oIMEM_REQ  = (r_state == S_RUN) && (w_used < LIMIT);
  assign oIMEM_ADDR = r_fetchPc;

  assign w_grant = oIMEM_REQ & iIMEM_GNT;
  assign w_pop   = r_irValid & iIR_READY;
  // A redirect in the same cycle wins over the returning word.
  assign w_push  = iIMEM_RVALID & (r_discard == '0) & ~iREDIRECT;

  assign w_inflightNext = r_inflight + CNTW'(w_grant) - CNTW'(iIMEM_RVALID);
  assign w_discardDec   = (iIMEM_RVALID && (r_discard != '0)) ? r_discard - CNTW'(1) : r_discard;
  // On redirect everything still owed by memory is stale and gets dropped.
  assign w_discardNext  = iREDIRECT ? w_inflightNext : w_discardDec;

  assign w_rdPtrInc   = (r_rdPtr == LASTPTR) ? '0 : r_rdPtr + PTRW'(1);
  assign w_wrPtrInc   = (r_wrPtr == LASTPTR) ? '0 : r_wrPtr + PTRW'(1);
  assign w_redirectPc = {iREDIRECT_PC[31:2], 2'b00};

  assign oIR_VALID = r_irValid;
  assign oIR       = r_ir;
  assign oOpcode   = r_ir[6:0];
  assign oPC       = r_pc;
  assign oMISALIGN = r_misalign;

  // Fetch FSM with PC, response-PC, in-flight and discard bookkeeping.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state    <= S_BOOT;
      r_fetchPc  <= RESET_PC;
      r_respPc   <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_inflight <= w_inflightNext;
      r_discard  <= w_discardNext;
      if (iREDIRECT) begin
        r_fetchPc  <= w_redirectPc;
        r_respPc   <= w_redirectPc;
        r_misalign <= |iREDIRECT_PC[1:0];
      end else begin
        if (w_grant) r_fetchPc <= r_fetchPc + 32'd4;
        if (w_push)  r_respPc  <= r_respPc + 32'd4;
      end
      case (r_state)
        S_BOOT:  r_state <= (w_discardNext != '0) ? S_FLUSH : S_RUN;
        S_RUN:   r_state <= (w_discardNext != '0) ? S_FLUSH : S_RUN;
        S_FLUSH: r_state <= (w_discardNext != '0) ? S_FLUSH : S_RUN;
        default: r_state <= S_BOOT;
      endcase
    end
  end

  // FIFO storage: each accepted word is written at the tail with its PC.
  always_ff @(posedge iCLK) begin
    if (w_push) begin
      r_memData[r_wrPtr] <= iIMEM_RDATA;
      r_memPc[r_wrPtr]   <= r_respPc;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (iREDIRECT) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)  r_rdPtr <= w_rdPtrInc;
      if (w_push) r_wrPtr <= w_wrPtrInc;
      r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
    end
  end

  // Registered copy of the FIFO head; holds the last word and PC when empty.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_irValid <= 1'b0;
      r_ir      <= '0;
      r_pc      <= RESET_PC;
    end else if (iREDIRECT) begin
      r_irValid <= 1'b0;
    end else if (w_pop && (r_count > CNTW'(1))) begin
      r_irValid <= 1'b1;
      r_ir      <= r_memData[w_rdPtrInc];
      r_pc      <= r_memPc[w_rdPtrInc];
    end else if (w_push && ((r_count == '0) || (w_pop && (r_count == CNTW'(1))))) begin
      r_irValid <= 1'b1;
      r_ir      <= iIMEM_RDATA;
      r_pc      <= r_respPc;
    end else if (w_pop) begin
      r_irValid <= 1'b0;
    end
  end

  // Memory must never return a word that was not requested.
  assert property (@(posedge iCLK) disable iff (!iRST_N) iIMEM_RVALID |-> (r_inflight != '0));

endmodule
